// File: rtl/barrett_modmul_ds_if.sv
// Bus bundle for barrett_modmul_ds: config port, operand/result handshakes, status.
// master = the side that drives operands/config, slave = the multiplier.
interface barrett_modmul_ds_if #(
  parameter int WIDTH = 256
);
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_n;
  logic [WIDTH:0]   cfg_mu;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             out_err;
  logic             busy;
  logic [2:0]       dbg_state;

  modport master (
    output cfg_we, cfg_n, cfg_mu, in_valid, a, b, out_ready,
    input  in_ready, out_valid, r, out_err, busy, dbg_state
  );

  modport slave (
    input  cfg_we, cfg_n, cfg_mu, in_valid, a, b, out_ready,
    output in_ready, out_valid, r, out_err, busy, dbg_state
  );
endinterface

// File: rtl/barrett_modmul_ds.sv
// Digit-serial Barrett modular multiplier r = (a*b) mod n, one DIGIT x (WIDTH+1) product per cycle.
// Optional macro BARRETT_OPERAND_CHECK_EN rejects operands >= n at the input handshake.
module barrett_modmul_ds #(
  parameter int WIDTH = 256,
  parameter int DIGIT = 64
) (
  input logic              clk,
  input logic              rst_n,
  barrett_modmul_ds_if.slave bus
);
  localparam int NA    = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int NB    = (WIDTH + DIGIT) / DIGIT;
  localparam int ACC_W = 2 * WIDTH + 2;
  localparam int PW    = WIDTH + 1 + DIGIT;
  localparam int SRC_W = NB * DIGIT;
  localparam int KW    = $clog2(WIDTH + 2);
  localparam int CW    = $clog2(NB + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_AB  = 3'd1,
    MUL_QMU = 3'd2,
    MUL_QN  = 3'd3,
    CORR1   = 3'd4,
    CORR2   = 3'd5,
    DONE    = 3'd6
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload stable while valid is high and ready is low.
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_reg, b_reg, n_reg;
  logic [WIDTH:0]     mu_reg;
  logic [KW-1:0]      k_reg;
  logic [2*WIDTH-1:0] x;
  logic [ACC_W-1:0]   q2, qn;
  logic [WIDTH+1:0]   rr;
  logic [WIDTH-1:0]   r_q;
  logic               out_valid_q, out_err_q, busy_q;
`ifdef BARRETT_OPERAND_CHECK_EN
  logic               range_err;
  logic [WIDTH-1:0]   n_eff;
`endif

  logic [WIDTH:0]     mcand, q1, q3;
  logic [SRC_W-1:0]   dsrc;
  logic [DIGIT-1:0]   digit;
  logic [PW-1:0]      partial;
  logic [ACC_W-1:0]   term;
  logic [WIDTH+1:0]   n_ext, r0, c1, c2;
  logic               fail_op;

  function automatic logic [KW-1:0] bit_len(input logic [WIDTH-1:0] v);
    bit_len = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) bit_len = KW'(i + 1);
  endfunction

  // One shared multiplier; the operand and digit source follow the phase.
  always_comb begin
    q1 = (k_reg <= KW'(1)) ? (WIDTH+1)'(x) : (WIDTH+1)'(x >> (k_reg - KW'(1)));
    q3 = (WIDTH+1)'(q2 >> (k_reg + KW'(1)));
    mcand = '0;
    dsrc  = '0;
    case (state)
      MUL_AB: begin
        mcand = {1'b0, a_reg};
        dsrc[WIDTH-1:0] = b_reg;
      end
      MUL_QMU: begin
        mcand = q1;
        dsrc[WIDTH:0] = mu_reg;
      end
      MUL_QN: begin
        mcand = {1'b0, n_reg};
        dsrc[WIDTH:0] = q3;
      end
      default: ;
    endcase
    digit   = DIGIT'(dsrc >> (int'(cnt) * DIGIT));
    partial = PW'(mcand) * PW'(digit);
    term    = ACC_W'(partial) << (int'(cnt) * DIGIT);
    n_ext   = {2'b00, n_reg};
    r0      = (WIDTH+2)'(x) - (WIDTH+2)'(qn);
    c1      = (r0 >= n_ext) ? r0 - n_ext : r0;
    c2      = (rr >= n_ext) ? rr - n_ext : rr;
    fail_op = (n_reg == '0);
`ifdef BARRETT_OPERAND_CHECK_EN
    if (range_err) fail_op = 1'b1;
    n_eff = bus.cfg_we ? bus.cfg_n : n_reg;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      n_reg       <= '0;
      mu_reg      <= '0;
      k_reg       <= '0;
      x           <= '0;
      q2          <= '0;
      qn          <= '0;
      rr          <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BARRETT_OPERAND_CHECK_EN
      range_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cfg_we) begin
            n_reg  <= bus.cfg_n;
            mu_reg <= bus.cfg_mu;
            k_reg  <= bit_len(bus.cfg_n);
          end
          if (bus.in_valid) begin
            a_reg  <= bus.a;
            b_reg  <= bus.b;
            x      <= '0;
            q2     <= '0;
            qn     <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
`ifdef BARRETT_OPERAND_CHECK_EN
            // Rejected operands go straight to the output stage, one cycle later.
            if (bus.a >= n_eff || bus.b >= n_eff) begin
              range_err <= 1'b1;
              state     <= CORR2;
            end else begin
              range_err <= 1'b0;
              state     <= MUL_AB;
            end
`else
            state  <= MUL_AB;
`endif
          end
        end
        MUL_AB: begin
          x <= x + (2*WIDTH)'(term);
          if (cnt == CW'(NA - 1)) begin
            cnt   <= '0;
            state <= MUL_QMU;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        MUL_QMU: begin
          q2 <= q2 + term;
          if (cnt == CW'(NB - 1)) begin
            cnt   <= '0;
            state <= MUL_QN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        MUL_QN: begin
          qn <= qn + term;
          if (cnt == CW'(NB - 1)) begin
            cnt   <= '0;
            state <= CORR1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CORR1: begin
          rr    <= c1;
          state <= CORR2;
        end
        CORR2: begin
          r_q         <= fail_op ? '0 : WIDTH'(c2);
          out_err_q   <= fail_op;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
`ifdef BARRETT_OPERAND_CHECK_EN
            range_err   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.r         = r_q;
  assign bus.out_err   = out_err_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_barrett_modmul_ds.sv
// Directed bench for barrett_modmul_ds at WIDTH=16, DIGIT=4 with hand-computed results.
module tb_barrett_modmul_ds;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int LAT   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  barrett_modmul_ds_if #(.WIDTH(WIDTH)) bus ();

  barrett_modmul_ds #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [WIDTH-1:0] n, input logic [WIDTH:0] mu);
    bus.cfg_n  = n;
    bus.cfg_mu = mu;
    bus.cfg_we = 1'b1;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_r, input logic exp_err,
                        input int exp_lat, input int hold,
                        input logic cfg_now, input logic [WIDTH-1:0] cn,
                        input logic [WIDTH:0] cmu);
    int cycles;
    logic [WIDTH-1:0] er;
    exp_q.push_back(exp_r);
    check("in_ready_idle", bus.in_ready, 1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    if (cfg_now) begin
      bus.cfg_n  = cn;
      bus.cfg_mu = cmu;
      bus.cfg_we = 1'b1;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    check("busy_run", bus.busy, 1);
    check("in_ready_run", bus.in_ready, 0);
    cycles = 0;
    while (!bus.out_valid && cycles < 64) begin
      tick();
      cycles++;
    end
    check("latency", cycles, exp_lat);
    er = exp_q.pop_front();
    check("r", bus.r, er);
    check("out_err", bus.out_err, exp_err);
    check("in_ready_done", bus.in_ready, 0);
    check("state_done", bus.dbg_state, 6);
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin
        bus.cfg_n  = 7;
        bus.cfg_mu = 36;
        bus.cfg_we = 1'b1;
      end
      tick();
      bus.cfg_we = 1'b0;
      check("hold_r", bus.r, er);
      check("hold_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("valid_clear", bus.out_valid, 0);
    check("in_ready_back", bus.in_ready, 1);
    check("busy_clear", bus.busy, 0);
  endtask

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_n     = '0;
    bus.cfg_mu    = '0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_r", bus.r, 0);
    check("rst_err", bus.out_err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_state", bus.dbg_state, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", bus.in_ready, 1);

    // Prime modulus 65521, mu = floor(2^32/65521) = 65551
    cfg_write(16'd65521, 17'h1000F);
    run_op(16'd12345, 16'd54321, 16'd50831, 1'b0, LAT, 0, 1'b0, '0, '0);
    run_op(16'd65520, 16'd65520, 16'd1,     1'b0, LAT, 0, 1'b0, '0, '0);
    run_op(16'd0,     16'd777,   16'd0,     1'b0, LAT, 0, 1'b0, '0, '0);

    // Small modulus 13, mu = floor(256/13) = 19
    cfg_write(16'd13, 17'd19);
    run_op(16'd7,  16'd9,  16'd11, 1'b0, LAT, 0, 1'b0, '0, '0);
    run_op(16'd12, 16'd12, 16'd1,  1'b0, LAT, 0, 1'b0, '0, '0);

    // Backpressure with a config write attempt while DONE; n must stay 13 (n=7 would give 4)
    run_op(16'd7,  16'd9,  16'd11, 1'b0, LAT, 10, 1'b0, '0, '0);
    run_op(16'd12, 16'd12, 16'd1,  1'b0, LAT, 0,  1'b0, '0, '0);

    // Reset in the middle of MUL_QMU
    bus.a        = 16'd3;
    bus.b        = 16'd4;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    check("mid_state_qmu", bus.dbg_state, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_r", bus.r, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_state", bus.dbg_state, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Unconfigured modulus n = 0
    run_op(16'd5, 16'd6, 16'd0, 1'b1, LAT, 0, 1'b0, '0, '0);

    // Config and operands in the same cycle: new n=13 applies
    run_op(16'd7, 16'd9, 16'd11, 1'b0, LAT, 0, 1'b1, 16'd13, 17'd19);

`ifdef BARRETT_OPERAND_CHECK_EN
    run_op(16'd13, 16'd2, 16'd0, 1'b1, 1, 0, 1'b0, '0, '0);
`else
    run_op(16'd7, 16'd9, 16'd11, 1'b0, LAT, 0, 1'b0, '0, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
